pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives the
//  per-boundary load enables (valid&ready) of the F/D, D/E, E/M and M/W

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RV32 pipeline. Produces the load
//   enables of the F/D, D/E, E/M and M/W registers plus the PC enable, and
//   sequences load-use bubbles, E-stage redirects, data-memory waits (with a
//   watchdog), the ebreak halt and the sticky memory error.
//   Optional feature macro: PIPE_PERF_CNT_EN (performance counters). When it
//   is not defined the counter outputs are tied to zero.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_E,
    input  logic [4:0]       Rd_E,
    input  logic             reg_ren_D,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             redirect_E,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    input  logic             ebreak_W,
    output logic             pc_en,
    output logic             en_FD,
    output logic             en_DE,
    output logic             en_EM,
    output logic             en_MW,
    output logic             flush_FD,
    output logic             flush_DE,
    output logic             wb_en,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    // Wait counter only needs to hold MEM_TIMEOUT; it saturates so a disabled
    // watchdog (MEM_TIMEOUT=0) never wraps into a false timeout.
    localparam int          TW    = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_V  = TW'(MEM_TIMEOUT);
    localparam bit          TO_EN = (MEM_TIMEOUT != 0);

    state_t          state_q, state_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic            wb_valid_q;

    logic            live;
    logic            frozen;
    logic            load_use;

    // The pipeline only moves in RUN/MEM_WAIT; a memory wait freezes everything.
    assign live     = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
    assign frozen   = !mem_ack && (((state_q == S_RUN) && mem_req_M) ||
                                   (state_q == S_MEM_WAIT));
    assign load_use = MemRead_E && (Rd_E != 5'd0) && reg_ren_D &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // wb_valid follows en_MW, so a frozen W register commits only once.
    assign wb_en  = wb_valid_q && live && !rst;
    assign halted = (state_q == S_HALT) && !rst;
    assign err    = (state_q == S_ERR) && !rst;

    // State register, wait counter and write-back valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wcnt_q     <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            wb_valid_q <= en_MW;
        end
    end

    // Next-state logic: halt on a committing ebreak, enter/leave memory wait,
    // trip the watchdog. HALT and ERR are left only through rst.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_RUN: begin
                if (wb_en && ebreak_W) begin
                    state_d = S_HALT;
                end else if (frozen) begin
                    state_d = S_MEM_WAIT;
                    wcnt_d  = TW'(1);
                end
            end
            S_MEM_WAIT: begin
                if (wb_en && ebreak_W) begin
                    state_d = S_HALT;
                end else if (mem_ack) begin
                    state_d = S_RUN;
                end else if (TO_EN && (wcnt_q >= TO_V)) begin
                    state_d = S_ERR;
                end else if (wcnt_q != {TW{1'b1}}) begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output logic: freeze > redirect > load-use bubble > normal flow.
    always_comb begin
        pc_en    = 1'b0;
        en_FD    = 1'b0;
        en_DE    = 1'b0;
        en_EM    = 1'b0;
        en_MW    = 1'b0;
        flush_FD = 1'b0;
        flush_DE = 1'b0;
        if (!rst && live && !frozen) begin
            en_DE = 1'b1;
            en_EM = 1'b1;
            en_MW = 1'b1;
            if (redirect_E) begin
                // The D instruction is on the wrong path, so a coincident
                // load-use hazard is irrelevant.
                pc_en    = 1'b1;
                en_FD    = 1'b1;
                flush_FD = 1'b1;
                flush_DE = 1'b1;
            end else if (load_use) begin
                flush_DE = 1'b1;
            end else begin
                pc_en = 1'b1;
                en_FD = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

    // Performance counters; all wrap modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (live && !pc_en) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_FD) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
